// File: rtl/encrip_pkg.sv
// Shared types and constants for the encrip_sched round-robin code-table scheduler.
package encrip_pkg;

  localparam int unsigned LEN_W_DEF  = 4;
  localparam int unsigned CODE_W_DEF = 5;
  localparam int unsigned SYM_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_CSUM  = 2'd2
  } state_t;

  // Symbol -> code table; element [n] is the code for symbol n.
  localparam logic [7:0][CODE_W_DEF-1:0] CODE_TABLE = {
    5'd8, 5'd20, 5'd11, 5'd10, 5'd6, 5'd9, 5'd1, 5'd7
  };

endpackage

// File: rtl/encrip_lut.sv
// Combinational 3-bit symbol to code lookup.
module encrip_lut
  import encrip_pkg::*;
#(
  parameter int unsigned CODE_W = CODE_W_DEF
) (
  input  logic [SYM_W-1:0]  i_sym,
  output logic [CODE_W-1:0] o_code
);

  assign o_code = CODE_W'(CODE_TABLE[i_sym]);

endmodule

// File: rtl/encrip_sched.sv
// Round-robin burst scheduler sharing one code table between two symbol sources.
// Optional trailing checksum word per burst when ENCRIP_CHECKSUM_EN is defined.
module encrip_sched
  import encrip_pkg::*;
#(
  parameter int unsigned LEN_W  = LEN_W_DEF,
  parameter int unsigned CODE_W = CODE_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        REQ,
  input  logic [LEN_W-1:0]  LEN0,
  input  logic [LEN_W-1:0]  LEN1,
  input  logic [SYM_W-1:0]  DIN0,
  input  logic [SYM_W-1:0]  DIN1,
  input  logic [1:0]        DVLD,
  output logic [1:0]        IN_RDY,
  output logic [1:0]        GNT,
  output logic [CODE_W-1:0] ECRo,
  output logic              OUT_VLD,
  input  logic              OUT_RDY,
  output logic              OUT_ID,
  output logic              OUT_LAST,
  output logic              OUT_CSUM,
  output logic              BUSY
);

  state_t             r_state, w_state_nxt;
  logic               r_g, w_g_nxt;
  logic               r_last_gnt, w_last_gnt_nxt;
  logic [LEN_W-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]         r_gnt, w_gnt_nxt;
  logic [CODE_W-1:0]  r_code, w_code_nxt;
  logic               r_vld, w_vld_nxt;
  logic               r_id, w_id_nxt;
  logic               r_last, w_last_nxt;
`ifdef ENCRIP_CHECKSUM_EN
  logic               r_csum, w_csum_nxt;
  logic [CODE_W-1:0]  r_sum, w_sum_nxt;
`endif

  logic               w_slot_free;
  logic               w_beat;
  logic [SYM_W-1:0]   w_sym;
  logic [CODE_W-1:0]  w_code;

  // Output register can take a new word when empty or being drained this cycle.
  assign w_slot_free = !r_vld || OUT_RDY;
  assign w_sym       = r_g ? DIN1 : DIN0;
  assign w_beat      = (r_state == ST_BURST) && DVLD[r_g] && w_slot_free;

  encrip_lut #(.CODE_W(CODE_W)) u_lut (
    .i_sym  (w_sym),
    .o_code (w_code)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_g_nxt        = r_g;
    w_last_gnt_nxt = r_last_gnt;
    w_cnt_nxt      = r_cnt;
    w_gnt_nxt      = r_gnt;
    w_code_nxt     = r_code;
    w_vld_nxt      = r_vld && !OUT_RDY;
    w_id_nxt       = r_id;
    w_last_nxt     = r_last;
`ifdef ENCRIP_CHECKSUM_EN
    w_csum_nxt     = r_csum;
    w_sum_nxt      = r_sum;
`endif

    case (r_state)
      ST_IDLE: begin
        if (REQ != 2'b00) begin
          w_g_nxt        = (REQ == 2'b11) ? !r_last_gnt : REQ[1];
          w_last_gnt_nxt = w_g_nxt;
          w_cnt_nxt      = w_g_nxt ? LEN1 : LEN0;
          w_gnt_nxt      = w_g_nxt ? 2'b10 : 2'b01;
          w_state_nxt    = ST_BURST;
`ifdef ENCRIP_CHECKSUM_EN
          w_sum_nxt      = '0;
`endif
        end
      end

      ST_BURST: begin
        if (w_beat) begin
          w_code_nxt = w_code;
          w_vld_nxt  = 1'b1;
          w_id_nxt   = r_g;
          w_last_nxt = 1'b0;
          w_cnt_nxt  = r_cnt - LEN_W'(1);
`ifdef ENCRIP_CHECKSUM_EN
          w_csum_nxt = 1'b0;
          w_sum_nxt  = r_sum + w_code;
`endif
          if (r_cnt == '0) begin
            w_gnt_nxt   = 2'b00;
`ifdef ENCRIP_CHECKSUM_EN
            w_state_nxt = ST_CSUM;
`else
            w_last_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
`endif
          end
        end
      end

`ifdef ENCRIP_CHECKSUM_EN
      ST_CSUM: begin
        if (w_slot_free) begin
          w_code_nxt  = r_sum;
          w_vld_nxt   = 1'b1;
          w_id_nxt    = r_g;
          w_last_nxt  = 1'b1;
          w_csum_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
`endif

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_g        <= 1'b0;
      r_last_gnt <= 1'b1;
      r_cnt      <= '0;
      r_gnt      <= 2'b00;
      r_code     <= '0;
      r_vld      <= 1'b0;
      r_id       <= 1'b0;
      r_last     <= 1'b0;
`ifdef ENCRIP_CHECKSUM_EN
      r_csum     <= 1'b0;
      r_sum      <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_g        <= w_g_nxt;
      r_last_gnt <= w_last_gnt_nxt;
      r_cnt      <= w_cnt_nxt;
      r_gnt      <= w_gnt_nxt;
      r_code     <= w_code_nxt;
      r_vld      <= w_vld_nxt;
      r_id       <= w_id_nxt;
      r_last     <= w_last_nxt;
`ifdef ENCRIP_CHECKSUM_EN
      r_csum     <= w_csum_nxt;
      r_sum      <= w_sum_nxt;
`endif
    end
  end

  assign IN_RDY   = (r_state == ST_BURST && w_slot_free) ? (r_g ? 2'b10 : 2'b01) : 2'b00;
  assign GNT      = r_gnt;
  assign ECRo     = r_code;
  assign OUT_VLD  = r_vld;
  assign OUT_ID   = r_id;
  assign OUT_LAST = r_last;
`ifdef ENCRIP_CHECKSUM_EN
  assign OUT_CSUM = r_csum;
`else
  assign OUT_CSUM = 1'b0;
`endif
  assign BUSY     = (r_state != ST_IDLE);

endmodule
